// File: rtl/tile_scheduler.sv
// tile_scheduler: issues one core job per ARRAY_DIM-square output tile of an M x K x N GEMM, row-major.
// start->core_start 1 cycle, core_valid->next start/done 2 cycles; `TILE_SCHED_PERF_EN adds perf_cycles_o.
module tile_scheduler #(
  parameter int ADDR_WIDTH = 16,
  parameter int ARRAY_DIM  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] m_i,
  input  logic [ADDR_WIDTH-1:0] k_i,
  input  logic [ADDR_WIDTH-1:0] n_i,
  input  logic [ADDR_WIDTH-1:0] base_addra_i,
  input  logic [ADDR_WIDTH-1:0] base_addrb_i,
  input  logic [ADDR_WIDTH-1:0] base_addrp_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  core_start_o,
  input  logic                  core_valid_i,
  output logic [ADDR_WIDTH-1:0] core_m_o,
  output logic [ADDR_WIDTH-1:0] core_k_o,
  output logic [ADDR_WIDTH-1:0] core_n_o,
  output logic [ADDR_WIDTH-1:0] core_base_addra_o,
  output logic [ADDR_WIDTH-1:0] core_base_addrb_o,
  output logic [ADDR_WIDTH-1:0] core_base_addrp_o,
  output logic [ADDR_WIDTH-1:0] tile_row_o,
  output logic [ADDR_WIDTH-1:0] tile_col_o
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  perf_cycles_o
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  localparam int                    SHIFT = $clog2(ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0] DIM   = ADDR_WIDTH'(ARRAY_DIM);
  localparam logic [ADDR_WIDTH:0]   ONE_W = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   RND_W = (ADDR_WIDTH+1)'(ARRAY_DIM - 1);

  state_t state, state_nxt;

  logic [ADDR_WIDTH:0]   mt, nt;
  logic [ADDR_WIDTH-1:0] k_q, n_q, base_b;
  logic [ADDR_WIDTH-1:0] rem_m, rem_n;
  logic [ADDR_WIDTH-1:0] row, col;
  logic [ADDR_WIDTH-1:0] addra, addrb, addrp;
  logic [ADDR_WIDTH-1:0] core_m, core_n;
  logic                  err_q;

  logic dims_ok, last_row, last_col;

  function automatic logic [ADDR_WIDTH-1:0] clamp(input logic [ADDR_WIDTH-1:0] x);
    return (x > DIM) ? DIM : x;
  endfunction

  assign dims_ok  = (m_i != '0) && (k_i != '0) && (n_i != '0);
  assign last_row = ({1'b0, row} == (mt - ONE_W));
  assign last_col = ({1'b0, col} == (nt - ONE_W));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy_o       = (state != IDLE);
    core_start_o = 1'b0;
    done_o       = 1'b0;
    err_o        = 1'b0;
    case (state)
      IDLE:  if (start_i) state_nxt = dims_ok ? ISSUE : DONE;
      ISSUE: begin
        core_start_o = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT:  if (core_valid_i) state_nxt = NEXT;
      NEXT:  state_nxt = (last_row && last_col) ? DONE : ISSUE;
      DONE: begin
        done_o    = 1'b1;
        err_o     = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining rows/cols are tracked so the tile clamp needs no multiply.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mt     <= '0;
      nt     <= '0;
      k_q    <= '0;
      n_q    <= '0;
      base_b <= '0;
      rem_m  <= '0;
      rem_n  <= '0;
      row    <= '0;
      col    <= '0;
      addra  <= '0;
      addrb  <= '0;
      addrp  <= '0;
      core_m <= '0;
      core_n <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          err_q <= !dims_ok;
          if (dims_ok) begin
            mt     <= ({1'b0, m_i} + RND_W) >> SHIFT;
            nt     <= ({1'b0, n_i} + RND_W) >> SHIFT;
            k_q    <= k_i;
            n_q    <= n_i;
            base_b <= base_addrb_i;
            rem_m  <= m_i;
            rem_n  <= n_i;
            row    <= '0;
            col    <= '0;
            addra  <= base_addra_i;
            addrb  <= base_addrb_i;
            addrp  <= base_addrp_i;
            core_m <= clamp(m_i);
            core_n <= clamp(n_i);
          end
        end
        NEXT: begin
          if (!last_col) begin
            col    <= col + 1'b1;
            addrb  <= addrb + k_q;
            addrp  <= addrp + DIM;
            rem_n  <= rem_n - DIM;
            core_n <= clamp(rem_n - DIM);
          end else if (!last_row) begin
            row    <= row + 1'b1;
            col    <= '0;
            addra  <= addra + k_q;
            addrb  <= base_b;
            addrp  <= addrp + DIM;
            rem_m  <= rem_m - DIM;
            core_m <= clamp(rem_m - DIM);
            rem_n  <= n_q;
            core_n <= clamp(n_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign core_m_o          = core_m;
  assign core_k_o          = k_q;
  assign core_n_o          = core_n;
  assign core_base_addra_o = addra;
  assign core_base_addrb_o = addrb;
  assign core_base_addrp_o = addrp;
  assign tile_row_o        = row;
  assign tile_col_o        = col;

`ifdef TILE_SCHED_PERF_EN
  logic [CNT_WIDTH-1:0] perf;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                             perf <= '0;
    else if (state == IDLE && start_i)       perf <= '0;
    else if (state != IDLE && perf != '1)    perf <= perf + CNT_WIDTH'(1);
  end

  assign perf_cycles_o = perf;
`endif

endmodule
